// File: rtl/cam_pkg.sv
// Shared constants for the camera frame capture block: geometry, FSM states,
// register map and STATUS flag positions.
package cam_pkg;

  localparam int unsigned IMG_W  = 320;
  localparam int unsigned IMG_H  = 240;
  localparam int unsigned ADDR_W = 17;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_CAPT = 2'd2
  } cap_state_e;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_LINES  = 4'h8;

  localparam int unsigned BIT_DONE  = 0;
  localparam int unsigned BIT_SHORT = 1;
  localparam int unsigned BIT_OVF   = 2;

endpackage

// File: rtl/cam_pixel_pack.sv
// Packs two camera bytes (high byte first) into one RGB565 pixel; a flush or
// clear drops any half-received pixel.
module cam_pixel_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  cam_byte,
  input  logic        flush,
  output logic        pix_vld_c,
  output logic [15:0] pix_data_c,
  output logic        odd_c
);

  logic       phase_q;
  logic [7:0] hi_q;

  always_ff @(posedge clk) begin
    if (rst || clear || flush) begin
      phase_q <= 1'b0;
    end else if (byte_vld) begin
      phase_q <= ~phase_q;
    end
    if (rst) begin
      hi_q <= '0;
    end else if (byte_vld && !phase_q) begin
      hi_q <= cam_byte;
    end
  end

  assign pix_vld_c  = byte_vld & phase_q;
  assign pix_data_c = {hi_q, cam_byte};
  assign odd_c      = phase_q;

endmodule

// File: rtl/cam_frame_capture.sv
// Captures one RGB565 frame from a DVP byte stream into CameraRAM, armed and
// monitored through a small AHB-Lite register file.
module cam_frame_capture #(
  parameter int unsigned IMG_W  = cam_pkg::IMG_W,
  parameter int unsigned IMG_H  = cam_pkg::IMG_H,
  parameter int unsigned ADDR_W = cam_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              cam_bvld,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  input  logic              HSELS,
  input  logic [31:0]       HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [31:0]       HWDATAS,
  input  logic              HREADYS,
  output logic [31:0]       HRDATAS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  output logic              FrameDone
);
  import cam_pkg::*;

  localparam logic [CNT_W-1:0] W_LIM = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_LIM = CNT_W'(IMG_H);

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
  logic [FLAG_W-1:0] flags_q, flags_d, set_c, w1c_c;
  logic              we_d, done_d, clr_all_c;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       wdata_d;

  logic vsync_q, href_q;
  logic vsync_fall_c, vsync_rise_c, href_fall_c;
  logic ahb_wr_q, ahb_sel_c, arm_c;
  logic [3:0] ahb_addr_q;
  logic capt_c, byte_vld_c, pix_vld_c, odd_c;
  logic [15:0] pix_data_c;
  logic unused_ok;

  assign vsync_fall_c = vsync_q & ~cam_vsync;
  assign vsync_rise_c = ~vsync_q & cam_vsync;
  assign href_fall_c  = href_q & ~cam_href;

  assign ahb_sel_c = HSELS & HTRANSS[1] & HREADYS;
  assign arm_c     = ahb_wr_q && (ahb_addr_q == REG_CTRL) && HWDATAS[0];
  assign w1c_c     = (ahb_wr_q && (ahb_addr_q == REG_STATUS)) ? HWDATAS[FLAG_W-1:0] : '0;

  assign HREADYOUTS = 1'b1;
  assign HRESPS     = 1'b0;
  assign unused_ok  = ^{HADDRS[31:4], HWDATAS[31:FLAG_W], HTRANSS[0]};

  assign capt_c     = (state_q == ST_CAPT);
  assign byte_vld_c = cam_bvld & cam_href & capt_c;

  cam_pixel_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (~capt_c),
    .byte_vld   (byte_vld_c),
    .cam_byte   (cam_data),
    .flush      (href_fall_c),
    .pix_vld_c  (pix_vld_c),
    .pix_data_c (pix_data_c),
    .odd_c      (odd_c)
  );

  // Next-state, counters, RAM write request and flag updates.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    we_d      = 1'b0;
    addr_d    = ram_addr;
    wdata_d   = ram_wdata;
    set_c     = '0;
    done_d    = 1'b0;
    clr_all_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm_c) begin
          state_d   = ST_SYNC;
          clr_all_c = 1'b1;
        end
      end
      ST_SYNC: begin
        if (vsync_fall_c) begin
          state_d = ST_CAPT;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_CAPT: begin
        if (pix_vld_c) begin
          if ((col_q < W_LIM) && (row_q < H_LIM)) begin
            we_d    = 1'b1;
            addr_d  = ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col_q);
            wdata_d = pix_data_c;
            col_d   = col_q + CNT_W'(1);
          end else begin
            set_c[BIT_OVF] = 1'b1;
          end
        end
        // Line close happens before any frame-end decision in the same cycle.
        if (href_fall_c) begin
          if ((col_q != W_LIM) || odd_c) set_c[BIT_SHORT] = 1'b1;
          if (row_q < H_LIM) row_d = row_q + CNT_W'(1);
          col_d = '0;
        end
        if (vsync_rise_c && (row_d < H_LIM)) set_c[BIT_SHORT] = 1'b1;
        if ((href_fall_c && (row_d == H_LIM)) || vsync_rise_c) begin
          set_c[BIT_DONE] = 1'b1;
          done_d          = 1'b1;
          we_d            = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    flags_d = clr_all_c ? '0 : ((flags_q & ~w1c_c) | set_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      flags_q    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      FrameDone  <= 1'b0;
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      ahb_wr_q   <= 1'b0;
      ahb_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      flags_q    <= flags_d;
      ram_we     <= we_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
      FrameDone  <= done_d;
      vsync_q    <= cam_vsync;
      href_q     <= cam_href;
      ahb_wr_q   <= ahb_sel_c & HWRITES;
      if (ahb_sel_c) ahb_addr_q <= HADDRS[3:0];
    end
  end

  // Read data follows the address latched in the preceding address phase.
  always_comb begin
    HRDATAS = '0;
    case (ahb_addr_q)
      REG_CTRL:   HRDATAS = {31'b0, (state_q != ST_IDLE)};
      REG_STATUS: HRDATAS = 32'(flags_q);
      REG_LINES:  HRDATAS = 32'(row_q);
      default:    HRDATAS = '0;
    endcase
  end

endmodule
